// File: rtl/nes_pkg.sv
// Shared definitions for the NES controller poller: FSM states and the
// button bit positions used by both the poller and any pad model.
package nes_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LATCH,
    WAIT_LO,
    CLK_HI,
    CLK_LO,
    DONE
  } state_t;

  localparam int NUM_BTNS   = 8;
  localparam int BTN_A      = 0;
  localparam int BTN_B      = 1;
  localparam int BTN_SELECT = 2;
  localparam int BTN_START  = 3;
  localparam int BTN_UP     = 4;
  localparam int BTN_DOWN   = 5;
  localparam int BTN_LEFT   = 6;
  localparam int BTN_RIGHT  = 7;

endpackage

// File: rtl/nes_sync.sv
// Two-flop synchronizer bringing the asynchronous pad data into the clk domain.
module nes_sync (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  // NOTE: clocked state uses non-blocking assignments so every flop samples
  // pre-edge values; blocking here would collapse the two stages into one.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/nes_poll_ctrl.sv
// NES pad poller: latches the pad, clocks out eight button bits, and publishes
// the active-high frame with valid/changed pulses, on request or periodically.
module nes_poll_ctrl
  import nes_pkg::*;
#(
  parameter int LATCH_CYCLES = 600,
  parameter int HALF_CYCLES  = 300,
  parameter int POLL_PERIOD  = 833333
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                auto_en,
  input  logic                nes_data,
  output logic                nes_latch,
  output logic                nes_clk,
  output logic [NUM_BTNS-1:0] buttons,
  output logic                valid,
  output logic                changed,
  output logic                busy
);

  localparam int TMR_MAX = (LATCH_CYCLES > HALF_CYCLES) ? LATCH_CYCLES : HALF_CYCLES;
  localparam int TMR_W   = $clog2(TMR_MAX);
  localparam int PER_W   = $clog2(POLL_PERIOD);

  localparam logic [TMR_W-1:0] LATCH_LAST = TMR_W'(LATCH_CYCLES - 1);
  localparam logic [TMR_W-1:0] HALF_LAST  = TMR_W'(HALF_CYCLES - 1);
  localparam logic [PER_W-1:0] PER_LAST   = PER_W'(POLL_PERIOD - 1);

  state_t              state;
  state_t              state_nxt;
  logic [TMR_W-1:0]    tmr;
  logic [PER_W-1:0]    per_cnt;
  logic [2:0]          bit_idx;
  logic [6:0]          shreg;
  logic                sync_data;
  logic                timer_done;
  logic                tick;
  logic                trigger;
  logic [NUM_BTNS-1:0] frame_next;

  nes_sync u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (nes_data),
    .q     (sync_data)
  );

  assign timer_done = (state == LATCH) ? (tmr == LATCH_LAST) : (tmr == HALF_LAST);
  assign tick       = auto_en && (per_cnt == PER_LAST);
  assign trigger    = (state == IDLE) && (start || tick);
  // Bit 7 comes straight from the synchronizer; bits 0..6 are already shifted in.
  assign frame_next = ~{sync_data, shreg};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // NOTE: every output of this block gets a default before the case, so no
  // path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_nxt = state;
    nes_latch = 1'b0;
    nes_clk   = 1'b0;
    busy      = 1'b1;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (trigger) state_nxt = LATCH;
      end
      LATCH: begin
        nes_latch = 1'b1;
        if (timer_done) state_nxt = WAIT_LO;
      end
      WAIT_LO: begin
        if (timer_done) state_nxt = CLK_HI;
      end
      CLK_HI: begin
        nes_clk = 1'b1;
        if (timer_done) state_nxt = CLK_LO;
      end
      CLK_LO: begin
        if (timer_done) state_nxt = (bit_idx == 3'd7) ? DONE : CLK_HI;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Phase timer restarts on every state change, so each phase lasts exactly
  // its programmed number of cycles.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                                   tmr <= '0;
    else if (state_nxt != state || state == IDLE) tmr <= '0;
    else                                          tmr <= tmr + TMR_W'(1);
  end

  // Frame registers load on the edge into DONE, so buttons, valid and changed
  // are all visible together during the single DONE cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      shreg   <= '0;
      bit_idx <= '0;
      buttons <= '0;
      valid   <= 1'b0;
      changed <= 1'b0;
    end else begin
      valid   <= 1'b0;
      changed <= 1'b0;
      if (state == WAIT_LO && timer_done) begin
        shreg   <= {sync_data, shreg[6:1]};
        bit_idx <= 3'd1;
      end else if (state == CLK_LO && timer_done) begin
        if (bit_idx == 3'd7) begin
          buttons <= frame_next;
          valid   <= 1'b1;
          changed <= (frame_next != buttons);
        end else begin
          shreg   <= {sync_data, shreg[6:1]};
          bit_idx <= bit_idx + 3'd1;
        end
      end
    end
  end

  // Period counter parks at its last value if the tick arrives mid-poll, so
  // the deferred tick fires as soon as the FSM is back in IDLE.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                   per_cnt <= '0;
    else if (!auto_en || trigger) per_cnt <= '0;
    else if (per_cnt != PER_LAST) per_cnt <= per_cnt + PER_W'(1);
  end

endmodule
